// File: rtl/expr_stream_checker_pkg.sv
// Shared definitions for the expression stream checker and the planned evaluator:
// state encoding, ASCII constants, operator-mask bit positions and the character-class record.
package expr_pkg;

   typedef enum logic [2:0] {
      EMPTY   = 3'd0,
      NUM     = 3'd1,
      CLOSE_S = 3'd2,
      EXPECT  = 3'd3,
      DEAD    = 3'd4
   } state_e;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_OPEN  = 8'h28;
   localparam logic [7:0] CH_CLOSE = 8'h29;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_DIV   = 8'h2F;

   localparam int OP_BIT_ADD = 0;
   localparam int OP_BIT_SUB = 1;
   localparam int OP_BIT_MUL = 2;
   localparam int OP_BIT_DIV = 3;

   // Indexed by OP_BIT_*, so OP_MASK[i] enables OP_CHARS[i].
   localparam logic [3:0][7:0] OP_CHARS = {CH_DIV, CH_MUL, CH_MINUS, CH_PLUS};

   typedef struct packed {
      logic digit;
      logic op;
      logic open;
      logic close;
      logic other;
   } char_class_t;

   function automatic int depth_w(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction

endpackage

// File: rtl/expr_stream_checker_if.sv
// Character stream in, validation status out; the character source is the master.
interface expr_stream_checker_if #(
   parameter int MAX_DEPTH = 7,
   parameter int POS_W     = 8
);
   localparam int DEPTH_W = expr_pkg::depth_w(MAX_DEPTH);

   logic               in_valid;
   logic [7:0]         in;
   logic               out;
   logic [DEPTH_W-1:0] depth;
   logic               dead;
   logic [POS_W-1:0]   err_pos;
   logic [POS_W-1:0]   count;

   modport master (
      output in_valid, in,
      input  out, depth, dead, err_pos, count
   );

   modport slave (
      input  in_valid, in,
      output out, depth, dead, err_pos, count
   );
endinterface

// File: rtl/expr_stream_checker_char_class.sv
// Combinational one-hot classifier of an ASCII character; disabled operators fall into "other".
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0]  ch,
   input  logic [3:0]  op_mask,
   output char_class_t cls
);
   logic [3:0] op_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_op
         assign op_hit[gi] = op_mask[gi] && (ch == OP_CHARS[gi]);
      end
   endgenerate

   always_comb begin
      cls       = '0;
      cls.digit = (ch >= CH_0) && (ch <= CH_9);
      cls.op    = |op_hit;
      cls.open  = (ch == CH_OPEN);
      cls.close = (ch == CH_CLOSE);
      cls.other = !(cls.digit || cls.op || cls.open || cls.close);
   end
endmodule

// File: rtl/expr_stream_checker.sv
// Streaming legality checker for ASCII arithmetic expressions: grammar FSM,
// parenthesis depth, character position and first-error position.
module expr_stream_checker
   import expr_pkg::*;
#(
   parameter int         MAX_DEPTH   = 7,
   parameter int         MULTI_DIGIT = 1,
   parameter logic [3:0] OP_MASK     = 4'b0101,
   parameter int         POS_W       = 8
)(
   input  logic                  clk,
   input  logic                  clr,
   expr_stream_checker_if.slave  bus
);
   localparam int DEPTH_W = depth_w(MAX_DEPTH);

   char_class_t        cls;
   state_e             state_q, state_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [POS_W-1:0]   count_q, count_d;
   logic [POS_W-1:0]   err_pos_q, err_pos_d;
   logic               out_q, out_d;
   logic               dead_q, dead_d;
   logic               go_dead;

   expr_char_class u_class (
      .ch      (bus.in),
      .op_mask (OP_MASK),
      .cls     (cls)
   );

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      count_d   = count_q;
      err_pos_d = err_pos_q;
      go_dead   = 1'b0;

      if (bus.in_valid) begin
         if (count_q != {POS_W{1'b1}}) begin
            count_d = count_q + POS_W'(1);
         end

         case (state_q)
            EMPTY, EXPECT: begin
               if (cls.other || cls.op || cls.close) begin
                  go_dead = 1'b1;
               end else if (cls.digit) begin
                  state_d = NUM;
               end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                  go_dead = 1'b1;
               end else begin
                  state_d = EXPECT;
                  depth_d = depth_q + DEPTH_W'(1);
               end
            end
            NUM, CLOSE_S: begin
               if (cls.digit && (state_q == NUM) && (MULTI_DIGIT != 0)) begin
                  state_d = NUM;
               end else if (cls.op) begin
                  state_d = EXPECT;
               end else if (cls.close && (depth_q != '0)) begin
                  state_d = CLOSE_S;
                  depth_d = depth_q - DEPTH_W'(1);
               end else begin
                  go_dead = 1'b1;
               end
            end
            default: ;
         endcase

         // count_q is already all-ones once saturated, which is the required error index then.
         if (go_dead) begin
            state_d   = DEAD;
            err_pos_d = count_q;
         end
      end

      out_d  = ((state_d == NUM) || (state_d == CLOSE_S)) && (depth_d == '0);
      dead_d = (state_d == DEAD);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= EMPTY;
         depth_q   <= '0;
         count_q   <= '0;
         err_pos_q <= '0;
         out_q     <= 1'b0;
         dead_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         count_q   <= count_d;
         err_pos_q <= err_pos_d;
         out_q     <= out_d;
         dead_q    <= dead_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.depth   = depth_q;
   assign bus.dead    = dead_q;
   assign bus.err_pos = err_pos_q;
   assign bus.count   = count_q;
endmodule

// File: tb/tb_expr_stream_checker.sv
// Scoreboard bench: the default-parameter instance is checked per character; variant
// instances (single-digit, depth 2/3, 4-bit positions) share the stream and are spot-checked.
module tb_expr_stream_checker;

   typedef struct {
      logic [7:0] ch;
      logic       o;
      logic [2:0] d;
      logic       dd;
      logic [7:0] e;
      logic [7:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_ch = 8'h00;
   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_cnt = 0;
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   expr_stream_checker_if #(.MAX_DEPTH(7), .POS_W(8)) m_if ();
   expr_stream_checker_if #(.MAX_DEPTH(7), .POS_W(8)) sd_if ();
   expr_stream_checker_if #(.MAX_DEPTH(2), .POS_W(8)) d2_if ();
   expr_stream_checker_if #(.MAX_DEPTH(3), .POS_W(8)) d3_if ();
   expr_stream_checker_if #(.MAX_DEPTH(7), .POS_W(4)) p4_if ();

   assign m_if.in_valid  = in_valid;  assign m_if.in  = in_ch;
   assign sd_if.in_valid = in_valid;  assign sd_if.in = in_ch;
   assign d2_if.in_valid = in_valid;  assign d2_if.in = in_ch;
   assign d3_if.in_valid = in_valid;  assign d3_if.in = in_ch;
   assign p4_if.in_valid = in_valid;  assign p4_if.in = in_ch;

   expr_stream_checker #(.MAX_DEPTH(7), .MULTI_DIGIT(1), .OP_MASK(4'b0101), .POS_W(8))
      u_dut (.clk(clk), .clr(clr), .bus(m_if));
   expr_stream_checker #(.MAX_DEPTH(7), .MULTI_DIGIT(0), .OP_MASK(4'b0101), .POS_W(8))
      u_sd  (.clk(clk), .clr(clr), .bus(sd_if));
   expr_stream_checker #(.MAX_DEPTH(2), .MULTI_DIGIT(1), .OP_MASK(4'b0101), .POS_W(8))
      u_d2  (.clk(clk), .clr(clr), .bus(d2_if));
   expr_stream_checker #(.MAX_DEPTH(3), .MULTI_DIGIT(1), .OP_MASK(4'b0101), .POS_W(8))
      u_d3  (.clk(clk), .clr(clr), .bus(d3_if));
   expr_stream_checker #(.MAX_DEPTH(7), .MULTI_DIGIT(1), .OP_MASK(4'b0101), .POS_W(4))
      u_p4  (.clk(clk), .clr(clr), .bus(p4_if));

   // Monitor: a character consumed at a rising edge is judged at the following falling edge.
   initial begin : monitor
      logic consumed;
      exp_t x;
      forever begin
         @(posedge clk);
         consumed = in_valid && !clr;
         @(negedge clk);
         if (consumed) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_underflow: got a consumed char, expected none queued");
            end else begin
               x = exp_q.pop_front();
               $display("char '%c' out=%0b depth=%0d dead=%0b err_pos=%0d count=%0d",
                        x.ch, m_if.out, m_if.depth, m_if.dead, m_if.err_pos, m_if.count);
               if ({m_if.out, m_if.depth, m_if.dead, m_if.count} !== {x.o, x.d, x.dd, x.c}) begin
                  n_fail++;
                  $display("FAIL char_'%c': got out=%0b depth=%0d dead=%0b count=%0d, expected out=%0b depth=%0d dead=%0b count=%0d",
                           x.ch, m_if.out, m_if.depth, m_if.dead, m_if.count, x.o, x.d, x.dd, x.c);
               end
               if (x.dd) begin
                  n_checks++;
                  if (m_if.err_pos !== x.e) begin
                     n_fail++;
                     $display("FAIL err_pos_'%c': got %0d, expected %0d", x.ch, m_if.err_pos, x.e);
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] ch, input logic e_out, input int e_depth,
                       input logic e_dead, input int e_err);
      exp_t x;
      @(negedge clk);
      in_valid = 1'b1;
      in_ch    = ch;
      if (exp_cnt < 255) exp_cnt++;
      x.ch = ch; x.o = e_out; x.d = 3'(e_depth); x.dd = e_dead; x.e = 8'(e_err); x.c = 8'(exp_cnt);
      exp_q.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_ch    = 8'($urandom);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2 clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({m_if.out, m_if.depth, m_if.dead, m_if.err_pos, m_if.count} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got out=%0b depth=%0d dead=%0b err_pos=%0d count=%0d, expected all 0",
                  m_if.out, m_if.depth, m_if.dead, m_if.err_pos, m_if.count);
      end
      clr = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      send("1", 1'b1, 0, 1'b0, 0);
      send("+", 1'b0, 0, 1'b0, 0);
      send("2", 1'b1, 0, 1'b0, 0);
      idle(1);
   endtask

   task automatic test_multi_digit();
      do_reset();
      send("(", 1'b0, 1, 1'b0, 0);
      send("1", 1'b0, 1, 1'b0, 0);
      send("2", 1'b0, 1, 1'b0, 0);
      send("*", 1'b0, 1, 1'b0, 0);
      send("3", 1'b0, 1, 1'b0, 0);
      send(")", 1'b1, 0, 1'b0, 0);
      idle(1);
      n_checks++;
      if ({sd_if.dead, sd_if.err_pos} !== {1'b1, 8'd2}) begin
         n_fail++;
         $display("FAIL single_digit: got dead=%0b err_pos=%0d, expected dead=1 err_pos=2",
                  sd_if.dead, sd_if.err_pos);
      end
   endtask

   task automatic test_nesting();
      do_reset();
      send("(", 1'b0, 1, 1'b0, 0);
      send("(", 1'b0, 2, 1'b0, 0);
      send("(", 1'b0, 3, 1'b0, 0);
      idle(1);
      n_checks++;
      if ({d2_if.dead, d2_if.err_pos, d2_if.depth} !== {1'b1, 8'd2, 2'd2}) begin
         n_fail++;
         $display("FAIL depth_limit_2: got dead=%0b err_pos=%0d depth=%0d, expected 1/2/2",
                  d2_if.dead, d2_if.err_pos, d2_if.depth);
      end
      n_checks++;
      if ({d3_if.dead, d3_if.out, d3_if.depth} !== {1'b0, 1'b0, 2'd3}) begin
         n_fail++;
         $display("FAIL depth_limit_3: got dead=%0b out=%0b depth=%0d, expected 0/0/3",
                  d3_if.dead, d3_if.out, d3_if.depth);
      end
   endtask

   task automatic test_errors();
      do_reset();
      send(")", 1'b0, 0, 1'b1, 0);
      do_reset();
      send("1", 1'b1, 0, 1'b0, 0);
      send("-", 1'b0, 0, 1'b1, 1);
      do_reset();
      send("(", 1'b0, 1, 1'b0, 0);
      send(")", 1'b0, 1, 1'b1, 1);
      do_reset();
      send("1", 1'b1, 0, 1'b0, 0);
      send(")", 1'b0, 0, 1'b1, 1);
      send("2", 1'b0, 0, 1'b1, 1);
      idle(1);
   endtask

   task automatic test_handshake();
      do_reset();
      send("(", 1'b0, 1, 1'b0, 0);
      send("1", 1'b0, 1, 1'b0, 0);
      send("+", 1'b0, 1, 1'b0, 0);
      idle(6);
      n_checks++;
      if ({m_if.out, m_if.depth, m_if.dead, m_if.count} !== {1'b0, 3'd1, 1'b0, 8'd3}) begin
         n_fail++;
         $display("FAIL idle_hold: got out=%0b depth=%0d dead=%0b count=%0d, expected 0/1/0/3",
                  m_if.out, m_if.depth, m_if.dead, m_if.count);
      end
      @(negedge clk);
      #2 clr = 1'b1;
      #1;
      n_checks++;
      if ({m_if.out, m_if.depth, m_if.dead, m_if.err_pos, m_if.count} !== '0) begin
         n_fail++;
         $display("FAIL async_clear: got out=%0b depth=%0d dead=%0b err_pos=%0d count=%0d before clk edge, expected all 0",
                  m_if.out, m_if.depth, m_if.dead, m_if.err_pos, m_if.count);
      end
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0;
      send("7", 1'b1, 0, 1'b0, 0);
      idle(1);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) send("1", 1'b1, 0, 1'b0, 0);
         else            send("+", 1'b0, 0, 1'b0, 0);
      end
      idle(1);
      n_checks++;
      if ({p4_if.count, p4_if.dead} !== {4'hF, 1'b0}) begin
         n_fail++;
         $display("FAIL count_saturate: got count=%0d dead=%0b, expected 15/0", p4_if.count, p4_if.dead);
      end
      do_reset();
      for (int i = 0; i < 18; i++) begin
         if (i % 2 == 0) send("1", 1'b1, 0, 1'b0, 0);
         else            send("+", 1'b0, 0, 1'b0, 0);
      end
      send(" ", 1'b0, 0, 1'b1, 18);
      send("1", 1'b0, 0, 1'b1, 18);
      idle(1);
      n_checks++;
      if ({p4_if.dead, p4_if.err_pos, p4_if.count} !== {1'b1, 4'hF, 4'hF}) begin
         n_fail++;
         $display("FAIL saturated_err_pos: got dead=%0b err_pos=%0d count=%0d, expected 1/15/15",
                  p4_if.dead, p4_if.err_pos, p4_if.count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_digit();
      test_nesting();
      test_errors();
      test_handshake();
      test_saturation();
      idle(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
